// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one memory port between instruction fetch and IEU load/store.
// Only one transaction is in flight at a time. Data normally wins
// arbitration, but after MAX_STREAK contested data wins fetch is forced
// through. A transaction that stalls in RESP for TIMEOUT cycles is
// aborted with Err. A response that arrives while no transaction is
// waiting for one sets the sticky ProtoErr.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's fields
// REQ   | MemReq held with stable fields until MemGnt is sampled high
// RESP  | granted; wait for MemRvalid or the timeout, then pulse Valid
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IFetchReq,
  input  logic [31:0] IFetchAdr,
  output logic [31:0] IFetchRdata,
  output logic        IFetchValid,
  input  logic        DataReq,
  input  logic [31:0] DataAdr,
  input  logic        DataWe,
  input  logic [3:0]  DataByteEn,
  input  logic [31:0] DataWdata,
  output logic [31:0] DataRdata,
  output logic        DataValid,
  output logic        Err,
  output logic        MemReq,
  output logic [31:0] MemAdr,
  output logic        MemWe,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWdata,
  input  logic        MemGnt,
  input  logic [31:0] MemRdata,
  input  logic        MemRvalid,
  output logic        Busy,
  output logic        ProtoErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        owner_data;
  logic [3:0]  streak;
  logic [7:0]  tcnt;

  logic        streak_full;
  logic        data_wins;
  logic        timeout_hit;
  logic        done;

  // Arbitration decision and end-of-transaction decode.
  always_comb begin
    streak_full = (streak == 4'(MAX_STREAK));
    data_wins   = DataReq && !(IFetchReq && streak_full);
    // tcnt counts completed RESP cycles, so the TIMEOUT-th RESP cycle is
    // the one where tcnt == TIMEOUT-1.
    timeout_hit = (state == RESP) && (tcnt == 8'(TIMEOUT - 1));
    done        = (state == RESP) && (MemRvalid || timeout_hit);
  end

  // Completion pulses are combinational so the owner sees the data in the
  // same cycle the memory returns it; a real response beats a timeout.
  assign IFetchValid = done && !owner_data;
  assign DataValid   = done && owner_data;
  assign Err         = done && !MemRvalid;
  assign IFetchRdata = (IFetchValid && MemRvalid) ? MemRdata : 32'd0;
  assign DataRdata   = (DataValid && MemRvalid) ? MemRdata : 32'd0;
  assign Busy        = (state != IDLE);

  // Main FSM: arbitration, field latching, grant handshake and timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      streak     <= 4'd0;
      tcnt       <= 8'd0;
      ProtoErr   <= 1'b0;
      MemReq     <= 1'b0;
      MemAdr     <= 32'd0;
      MemWe      <= 1'b0;
      MemByteEn  <= 4'd0;
      MemWdata   <= 32'd0;
    end else begin
      // Any response outside RESP, including one arriving after a timeout
      // abort, is a memory-side protocol violation and is otherwise ignored.
      if (MemRvalid && (state != RESP)) begin
        ProtoErr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (IFetchReq || DataReq) begin
            state  <= REQ;
            MemReq <= 1'b1;
            tcnt   <= 8'd0;
            if (data_wins) begin
              owner_data <= 1'b1;
              MemAdr     <= DataAdr;
              MemWe      <= DataWe;
              MemByteEn  <= DataWe ? DataByteEn : 4'hF;
              MemWdata   <= DataWe ? DataWdata : 32'd0;
              // Only a win that fetch contested counts toward the streak.
              if (IFetchReq) begin
                streak <= streak_full ? streak : streak + 4'd1;
              end else begin
                streak <= 4'd0;
              end
            end else begin
              owner_data <= 1'b0;
              MemAdr     <= IFetchAdr;
              MemWe      <= 1'b0;
              MemByteEn  <= 4'hF;
              MemWdata   <= 32'd0;
              streak     <= 4'd0;
            end
          end
        end
        REQ: begin
          if (MemGnt) begin
            MemReq <= 1'b0;
            tcnt   <= 8'd0;
            state  <= RESP;
          end
        end
        RESP: begin
          if (MemRvalid || timeout_hit) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: requester and memory models run as
// background processes; expected completions and grant order are queued
// when stimulus is issued and consumed as the DUT produces them.
module tb_mem_port_arbiter;
  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IFetchReq;
  logic [31:0] IFetchAdr;
  logic [31:0] IFetchRdata;
  logic        IFetchValid;
  logic        DataReq;
  logic [31:0] DataAdr;
  logic        DataWe;
  logic [3:0]  DataByteEn;
  logic [31:0] DataWdata;
  logic [31:0] DataRdata;
  logic        DataValid;
  logic        Err;
  logic        MemReq;
  logic [31:0] MemAdr;
  logic        MemWe;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWdata;
  logic        MemGnt;
  logic [31:0] MemRdata;
  logic        MemRvalid;
  logic        Busy;
  logic        ProtoErr;

  mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .IFetchReq(IFetchReq), .IFetchAdr(IFetchAdr),
    .IFetchRdata(IFetchRdata), .IFetchValid(IFetchValid),
    .DataReq(DataReq), .DataAdr(DataAdr), .DataWe(DataWe),
    .DataByteEn(DataByteEn), .DataWdata(DataWdata),
    .DataRdata(DataRdata), .DataValid(DataValid), .Err(Err),
    .MemReq(MemReq), .MemAdr(MemAdr), .MemWe(MemWe),
    .MemByteEn(MemByteEn), .MemWdata(MemWdata), .MemGnt(MemGnt),
    .MemRdata(MemRdata), .MemRvalid(MemRvalid),
    .Busy(Busy), .ProtoErr(ProtoErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  cmd_t fetch_cmds[$];
  cmd_t data_cmds[$];
  cmd_t cur_f;
  cmd_t cur_d;
  exp_t exp_f[$];
  exp_t exp_d[$];
  logic exp_gnt[$];   // 1 = data expected to win next, 0 = fetch

  int errors = 0;
  int checks = 0;

  // memory model controls and state
  int          gnt_delay  = 0;
  int          rsp_delay  = 0;
  bit          rsp_enable = 1'b1;
  bit          gnt_q      = 1'b0;
  bit          pending    = 1'b0;
  bit          in_req     = 1'b0;
  bit          have_owner = 1'b0;
  logic        cur_owner  = 1'b0;
  int          gcnt       = 0;
  int          rcnt       = 0;
  int          valid_rcnt = 0;
  logic [31:0] pdata      = 32'd0;
  cmd_t        mc;
  logic [31:0] ea, ewd;
  logic        ew;
  logic [3:0]  eb;
  exp_t        me;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  // Memory model: grant after gnt_delay REQ cycles, respond after rsp_delay
  // RESP cycles; checks the request fields against the expected winner.
  initial begin
    MemGnt = 1'b0; MemRvalid = 1'b0; MemRdata = 32'd0;
    forever begin
      @(negedge clk);
      MemGnt = 1'b0; MemRvalid = 1'b0; MemRdata = 32'd0;
      if (!reset_n) begin
        gnt_q = 1'b0; pending = 1'b0; in_req = 1'b0;
        continue;
      end
      if (gnt_q) begin
        pending = 1'b1; rcnt = 0; gnt_q = 1'b0;
      end
      if (pending) begin
        if (rsp_enable && rcnt >= rsp_delay) begin
          MemRvalid = 1'b1; MemRdata = pdata; pending = 1'b0;
        end else begin
          rcnt++;
        end
      end else if (MemReq === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1; gcnt = 0;
          if (exp_gnt.size() == 0) begin
            have_owner = 1'b0;
            errors++;
            $display("FAIL unexpected_grant: MemReq with adr=%h, required no request", MemAdr);
          end else begin
            have_owner = 1'b1;
            cur_owner  = exp_gnt.pop_front();
          end
        end
        if (have_owner) begin
          mc  = cur_owner ? cur_d : cur_f;
          ea  = mc.adr;
          ew  = cur_owner ? mc.we : 1'b0;
          eb  = (cur_owner && mc.we) ? mc.be : 4'hF;
          ewd = (cur_owner && mc.we) ? mc.wdata : 32'd0;
          checks++;
          if ({MemAdr, MemWe, MemByteEn, MemWdata} !== {ea, ew, eb, ewd}) begin
            errors++;
            $display("FAIL mem_fields(owner=%0s): got adr=%h we=%b be=%h wd=%h, required adr=%h we=%b be=%h wd=%h",
                     cur_owner ? "data" : "fetch", MemAdr, MemWe, MemByteEn, MemWdata, ea, ew, eb, ewd);
          end
        end
        if (gcnt >= gnt_delay) begin
          MemGnt = 1'b1; gnt_q = 1'b1; in_req = 1'b0; pdata = mem_val(MemAdr);
        end else begin
          gcnt++;
        end
      end
    end
  end

  // Requester models and completion scoreboard.
  initial begin
    IFetchReq = 1'b0; IFetchAdr = 32'd0;
    DataReq = 1'b0; DataAdr = 32'd0; DataWe = 1'b0; DataByteEn = 4'd0; DataWdata = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        IFetchReq = 1'b0; DataReq = 1'b0;
        continue;
      end
      checks++;
      if (IFetchValid === 1'b1) begin
        valid_rcnt = rcnt;
        if (exp_f.size() == 0) begin
          errors++;
          $display("FAIL fetch_valid: unexpected pulse rdata=%h err=%b, required no pulse", IFetchRdata, Err);
        end else begin
          me = exp_f.pop_front();
          if ({Err, IFetchRdata} !== {me.err, me.rdata}) begin
            errors++;
            $display("FAIL fetch_result: got err=%b rdata=%h, required err=%b rdata=%h", Err, IFetchRdata, me.err, me.rdata);
          end
        end
        if (DataValid !== 1'b0) begin
          errors++;
          $display("FAIL both_valid: DataValid=%b with IFetchValid, required 0", DataValid);
        end
        IFetchReq = 1'b0;
      end else if (IFetchRdata !== 32'd0) begin
        errors++;
        $display("FAIL fetch_rdata_idle: got %h, required 0", IFetchRdata);
      end
      checks++;
      if (DataValid === 1'b1) begin
        valid_rcnt = rcnt;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL data_valid: unexpected pulse rdata=%h err=%b, required no pulse", DataRdata, Err);
        end else begin
          me = exp_d.pop_front();
          if ({Err, DataRdata} !== {me.err, me.rdata}) begin
            errors++;
            $display("FAIL data_result: got err=%b rdata=%h, required err=%b rdata=%h", Err, DataRdata, me.err, me.rdata);
          end
        end
        DataReq = 1'b0;
      end else if (DataRdata !== 32'd0) begin
        errors++;
        $display("FAIL data_rdata_idle: got %h, required 0", DataRdata);
      end
      if (IFetchValid !== 1'b1 && DataValid !== 1'b1 && Err !== 1'b0) begin
        errors++;
        $display("FAIL err_idle: got Err=%b without Valid, required 0", Err);
      end
      if (!IFetchReq && fetch_cmds.size() > 0) begin
        cur_f = fetch_cmds.pop_front();
        IFetchAdr = cur_f.adr; IFetchReq = 1'b1;
        exp_f.push_back('{cur_f.exp_err, cur_f.exp_err ? 32'd0 : mem_val(cur_f.adr)});
      end
      if (!DataReq && data_cmds.size() > 0) begin
        cur_d = data_cmds.pop_front();
        DataAdr = cur_d.adr; DataWe = cur_d.we; DataByteEn = cur_d.be; DataWdata = cur_d.wdata;
        DataReq = 1'b1;
        exp_d.push_back('{cur_d.exp_err, cur_d.exp_err ? 32'd0 : mem_val(cur_d.adr)});
      end
    end
  end

  task automatic wait_done(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      #4;
      if (fetch_cmds.size() == 0 && data_cmds.size() == 0 && exp_f.size() == 0 &&
          exp_d.size() == 0 && exp_gnt.size() == 0 && Busy === 1'b0 &&
          IFetchReq === 1'b0 && DataReq === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done: busy=%b exp_f=%0d exp_d=%0d exp_gnt=%0d after %0d cycles, required idle",
               name, Busy, exp_f.size(), exp_d.size(), exp_gnt.size(), max_cyc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({MemReq, MemAdr, MemWe, MemByteEn, MemWdata, IFetchValid, IFetchRdata, DataValid,
         DataRdata, Err, Busy, ProtoErr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b adr=%h busy=%b perr=%b, required all 0", MemReq, MemAdr, Busy, ProtoErr);
    end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    gnt_delay = 0; rsp_delay = 1;
    exp_gnt.push_back(1'b0);
    fetch_cmds.push_back('{32'h0000_0100, 1'b0, 4'h0, 32'd0, 1'b0});
    @(negedge clk);
    #3;
    checks++;
    if (MemReq !== 1'b0 || IFetchReq !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_cycle0: got MemReq=%b IFetchReq=%b, required 0 and 1", MemReq, IFetchReq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (MemReq !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_cycle1: got MemReq=%b Busy=%b, required 1 and 1", MemReq, Busy);
    end
    wait_done(20, "single_fetch");
  endtask

  task automatic test_store_load();
    gnt_delay = 0; rsp_delay = 0;
    exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b1);
    data_cmds.push_back('{32'h0000_2004, 1'b1, 4'b0011, 32'h0000_1234, 1'b0});
    data_cmds.push_back('{32'h0000_3008, 1'b0, 4'b0101, 32'hFFFF_FFFF, 1'b0});
    wait_done(20, "store_load");
  endtask

  task automatic test_contention();
    gnt_delay = 0; rsp_delay = 0;
    for (int i = 0; i < 11; i++) begin
      exp_gnt.push_back((i == 4 || i == 9) ? 1'b0 : 1'b1);
    end
    fetch_cmds.push_back('{32'h0000_1000, 1'b0, 4'h0, 32'd0, 1'b0});
    fetch_cmds.push_back('{32'h0000_1004, 1'b0, 4'h0, 32'd0, 1'b0});
    for (int i = 0; i < 9; i++) begin
      data_cmds.push_back('{32'h0000_2000 + 32'(4 * i), 1'(i % 2), 4'(i + 1), 32'h1111_0000 + 32'(i), 1'b0});
    end
    // 11 back-to-back transactions at 3 cycles each must finish within 38.
    wait_done(38, "contention");
  endtask

  task automatic test_timeout();
    gnt_delay = 0; rsp_delay = 0; rsp_enable = 1'b0;
    exp_gnt.push_back(1'b0);
    fetch_cmds.push_back('{32'h0000_4000, 1'b0, 4'h0, 32'd0, 1'b1});
    wait_done(TIMEOUT + 10, "timeout");
    checks++;
    if (valid_rcnt != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles: abort after %0d RESP cycles, required %0d", valid_rcnt, TIMEOUT);
    end
    checks++;
    if (ProtoErr !== 1'b0) begin
      errors++;
      $display("FAIL proto_before_stray: got %b, required 0", ProtoErr);
    end
    rsp_enable = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (ProtoErr !== 1'b1) begin
      errors++;
      $display("FAIL proto_after_stray: got %b, required 1", ProtoErr);
    end
  endtask

  task automatic test_timeout_boundary();
    // Response on the very cycle the timeout would fire: response wins.
    gnt_delay = 0; rsp_delay = TIMEOUT - 1; rsp_enable = 1'b1;
    exp_gnt.push_back(1'b1);
    data_cmds.push_back('{32'h0000_6010, 1'b0, 4'h0, 32'd0, 1'b0});
    wait_done(TIMEOUT + 10, "timeout_boundary");
    checks++;
    if (valid_rcnt != TIMEOUT - 1) begin
      errors++;
      $display("FAIL boundary_cycles: response after %0d, required %0d", valid_rcnt, TIMEOUT - 1);
    end
    rsp_delay = 0;
  endtask

  task automatic test_grant_stall();
    int  nreq;
    bit  got;
    gnt_delay = 10; rsp_delay = 0;
    exp_gnt.push_back(1'b1);
    data_cmds.push_back('{32'h0000_5000, 1'b1, 4'b1100, 32'hCAFE_F00D, 1'b0});
    nreq = 0; got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      #4;
      if (MemReq === 1'b1) got = 1'b1;
    end
    if (got) nreq = 1;
    for (int n = 0; n < 30 && got; n++) begin
      @(negedge clk);
      #4;
      if (MemReq === 1'b1) nreq++;
      else break;
    end
    checks++;
    if (nreq != 11) begin
      errors++;
      $display("FAIL stall_req_cycles: MemReq high %0d cycles, required 11", nreq);
    end
    wait_done(20, "grant_stall");
    gnt_delay = 0;
  endtask

  task automatic test_reset_midop();
    bit in_resp;
    rsp_delay = 20;
    exp_gnt.push_back(1'b1);
    data_cmds.push_back('{32'h0000_7000, 1'b1, 4'hF, 32'h5555_AAAA, 1'b0});
    in_resp = 1'b0;
    for (int n = 0; n < 10 && !in_resp; n++) begin
      @(negedge clk);
      #4;
      if (Busy === 1'b1 && MemReq === 1'b0) in_resp = 1'b1;
    end
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!in_resp || {MemReq, MemAdr, MemWe, MemByteEn, MemWdata, IFetchValid, IFetchRdata,
                     DataValid, DataRdata, Err, Busy, ProtoErr} !== '0) begin
      errors++;
      $display("FAIL reset_midop: in_resp=%b adr=%h we=%b busy=%b perr=%b, required in_resp=1 and all 0",
               in_resp, MemAdr, MemWe, Busy, ProtoErr);
    end
    fetch_cmds.delete(); data_cmds.delete();
    exp_f.delete(); exp_d.delete(); exp_gnt.delete();
    rsp_delay = 0;
    repeat (2) @(negedge clk);
    #3;
    reset_n = 1'b1;
    exp_gnt.push_back(1'b1);
    data_cmds.push_back('{32'h0000_7004, 1'b0, 4'h0, 32'd0, 1'b0});
    wait_done(20, "after_reset");
    checks++;
    if (ProtoErr !== 1'b0) begin
      errors++;
      $display("FAIL proto_after_reset: got %b, required 0", ProtoErr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_timeout();
    test_timeout_boundary();
    test_grant_stall();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester and the IEU load/store requester.
- Serialises all accesses: one outstanding transaction at a time.
- Data accesses have priority; an anti-starvation counter guarantees forward progress for fetch.
- Applies a response timeout and flags memory-side protocol violations.

Parameters:
- MAX_STREAK, 4, consecutive contested data grants allowed before fetch is forced to win (1..15).
- TIMEOUT, 64, cycles in RESP without MemRvalid before the transaction is aborted with error (2..255).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- IFetchReq  in  1  fetch request; held until IFetchValid
- IFetchAdr  in  32  fetch address; stable while IFetchReq
- IFetchRdata  out  32  fetch read data, qualified by IFetchValid
- IFetchValid  out  1  one-cycle completion pulse to fetch
- DataReq  in  1  IEU request (MemEn); held until DataValid
- DataAdr  in  32  IEU address (IEUAdr)
- DataWe  in  1  1 = store, 0 = load
- DataByteEn  in  4  store byte enables (WriteByteEn)
- DataWdata  in  32  store data
- DataRdata  out  32  load data, qualified by DataValid
- DataValid  out  1  one-cycle completion pulse to IEU
- Err  out  1  qualifies the current Valid pulse as a timeout abort
- MemReq  out  1  memory request, registered
- MemAdr  out  32  latched address
- MemWe  out  1  latched write flag (0 for fetch)
- MemByteEn  out  4  latched byte enables (4'b1111 for fetch and for loads)
- MemWdata  out  32  latched store data (0 for fetch)
- MemGnt  in  1  memory accepts request this cycle
- MemRdata  in  32  memory read data
- MemRvalid  in  1  response/ack; used for reads and writes
- Busy  out  1  state != IDLE
- ProtoErr  out  1  sticky: MemRvalid seen outside RESP

Behaviour:
- States and transitions:
  - IDLE -> REQ on any request.
  - REQ -> RESP on MemGnt.
  - RESP -> IDLE on MemRvalid or on timeout.
- Reset (reset_n low, asynchronous):
  - State IDLE; owner, streak, timeout counter and ProtoErr cleared.
  - All Mem* outputs 0.
  - Valid, Err and Busy 0.
  - Any in-flight transaction is abandoned.
- Arbitration (IDLE only, evaluated each cycle):
  - Only DataReq: data wins.
  - Only IFetchReq: fetch wins.
  - Both requesting: data wins unless streak == MAX_STREAK, in which case fetch wins.
- Streak counter:
  - +1 when data wins while IFetchReq is high.
  - Cleared when fetch wins, or when data wins with IFetchReq low.
  - Saturates at MAX_STREAK.
- Grant: at the grant edge the winner's fields are latched into Mem* and the owner register, and MemReq is set.
  - MemReq is high the cycle after the request first appears in IDLE.
- REQ:
  - MemReq and all fields held stable until MemGnt is sampled high.
  - MemGnt sampled high: clear MemReq and enter RESP.
  - No timeout in REQ.
- RESP:
  - Timeout counter increments each cycle.
  - MemRvalid high: owner's Valid = 1 combinationally in that cycle; Rdata = MemRdata passthrough; non-owner Valid = 0; next state IDLE.
  - Counter reaches TIMEOUT with no MemRvalid: owner's Valid = 1 and Err = 1, Rdata = 0; next state IDLE.
  - MemRvalid and timeout in the same cycle: MemRvalid wins, Err = 0.
- Back-to-back: the requester drops or changes its request on the edge after Valid; the arbiter re-arbitrates in IDLE on the next cycle.
  - Minimum transaction period is 3 cycles: IDLE, REQ with immediate MemGnt, RESP with immediate MemRvalid.
- Request withdrawal: Req dropped after grant is ignored; the transaction completes and Valid still pulses.
- Protocol error: MemRvalid in IDLE or REQ, including late responses after a timeout, sets ProtoErr.
  - The response is otherwise ignored.
  - ProtoErr clears only on reset.
- Outside a Valid pulse, both Rdata outputs are 0.

Test Plan:
- Single fetch: IFetchReq=1, IFetchAdr=0x100, MemGnt immediate, MemRvalid 2 cycles later with MemRdata=0xDEADBEEF -> MemReq at cycle 1, MemAdr=0x100, MemWe=0, MemByteEn=4'hF, IFetchValid pulses with IFetchRdata=0xDEADBEEF, Err=0, Busy low afterwards.
- Store: DataReq=1, DataWe=1, DataAdr=0x2004, DataByteEn=4'b0011, DataWdata=0x1234 -> Mem* fields match exactly; DataValid pulses on MemRvalid; IFetchValid stays 0.
- Contention starvation: both requesting continuously, MAX_STREAK=4, zero-wait memory -> grant order D,D,D,D,F,D,D,D,D,F.
- Timeout: fetch granted, MemRvalid never asserted, TIMEOUT=64 -> IFetchValid=1 and Err=1 with IFetchRdata=0 after 64 RESP cycles; a later stray MemRvalid sets ProtoErr=1.
- Grant stall: MemGnt held low for 10 cycles -> MemReq and fields stable all 10 cycles; no timeout; completes normally once granted.
- Reset mid-op: reset_n low during RESP -> all outputs 0 asynchronously; after release a new DataReq is served normally.
